bcd_gray_arbiter: RTL and testbench
===================================

Name: bcd_gray_arbiter

Overview:
Shares a single registered BCD-to-Gray conversion stage between two requesters using round-robin arbitration and a req/done handshake.
- Converts one 4-bit BCD digit per transaction: gray = b ^ (b >> 1).
- Flags non-BCD inputs (10..15) with an error bit.
- Keeps a running count of successful conversions.
- Sits between digit-producing blocks and the display/encoder path that consumes Gray codes.

Parameters:
CNT_W, 8, width of the successful-conversion counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 request; held high with bcd0 stable until done0
bcd0  input  4  requester 0 BCD digit
req1  input  1  requester 1 request
bcd1  input  4  requester 1 BCD digit
gnt0  output  1  requester 0 owns the converter
gnt1  output  1  requester 1 owns the converter
done0  output  1  one-cycle pulse: result for requester 0 valid on gray/err
done1  output  1  one-cycle pulse: result for requester 1 valid on gray/err
gray  output  4  converted Gray code; holds its last value between transactions
err  output  1  operand was > 9 (valid with done*)
busy  output  1  state != IDLE
conv_count  output  CNT_W  number of successful (err=0) conversions

Behaviour:
- One clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - gnt0, gnt1, done0, done1, err, busy = 0.
  - gray = 4'b0000.
  - conv_count = 0.
  - state = IDLE.
  - last-served pointer = 1, so requester 0 wins the first tie.
- FSM states: IDLE, LOAD, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester not equal to the last-served pointer.
  - On the edge that leaves IDLE: capture the granted bcd into the operand register, set gnt_i = 1, go to LOAD.
- LOAD:
  - gnt_i = 1, busy = 1.
  - The edge leaving LOAD registers the result:
    - operand <= 9: gray = operand ^ (operand >> 1), err = 0.
    - operand > 9: gray = 4'b0000, err = 1.
  - Go to RESP.
- RESP:
  - done_i = 1 for exactly this cycle; gnt_i stays 1.
  - Update the last-served pointer to i.
  - Increment conv_count only if err = 0. It wraps silently from all-ones to 0.
  - Next state is IDLE unconditionally. gnt_i and done_i deassert there.
- Latency: req first sampled high in IDLE at edge E.
  - gnt_i rises after E.
  - done_i is high in the cycle after E+1 and falls after E+2.
  - Maximum throughput: one transaction per 3 cycles.
- A requester still holding req in IDLE after its done is treated as a new request.
  - When both requesters stay asserted, service alternates 0,1,0,1,...
- Inputs:
  - bcd_i is sampled only on the IDLE->LOAD edge; later changes do not affect the transaction in flight.
  - req changes during LOAD/RESP are ignored until IDLE.
  - Dropping req mid-transaction does not cancel it; done still pulses.
- Mutual exclusion:
  - gnt0 and gnt1 are never both 1.
  - done0 and done1 are never both 1.
  - done_i implies gnt_i.
- Reset mid-transaction (LOAD or RESP):
  - The transaction is abandoned and no done pulse is issued.
  - All outputs and the pointer return to reset values on that edge.
  - rst dominates all other inputs.
- The err path does not touch conv_count. gray is forced to 0000 on error so downstream never sees a stale code tagged valid.

Test Plan:
- Reset, then req0=1, bcd0=7 for one transaction -> gnt0 high 2 cycles; done0 pulse with gray=0100, err=0; conv_count=1; gnt1/done1 stay 0.
- Sequential req1 digits 0,3,5,9 -> gray 0000, 0010, 0111, 1101; done1 spacing exactly 3 cycles; conv_count=4.
- req0=1, bcd0=12 -> done0 with err=1, gray=0000; conv_count unchanged. A following bcd0=9 gives gray=1101, err=0.
- req0 and req1 both held high from reset, bcd0=2, bcd1=8 -> done order 0,1,0,1; grays 0011 (for 2) and 1100 (for 8); gnt/done never overlap.
- Assert rst during LOAD of a req0 transaction -> no done0; all outputs 0 next cycle; a subsequent req1 is granted first and completes normally.
- CNT_W=2, five successful conversions -> conv_count sequence 1,2,3,0,1. Change bcd0 during LOAD -> the result reflects the value captured at grant.

Source files
------------

// File: rtl/bcd_gray_arbiter.sv
// Two-requester round-robin front end for one registered BCD-to-Gray stage.
// A transaction is IDLE -> LOAD -> RESP; done pulses in RESP with gray/err valid.
module bcd_gray_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [3:0]       bcd0,
    input  logic             req1,
    input  logic [3:0]       bcd1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [3:0]       gray,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] conv_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;   // requester owning the current transaction
    logic               ptr_q, ptr_d;   // last-served requester
    logic [3:0]         opnd_q, opnd_d;
    logic [3:0]         gray_q, gray_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b1;
            opnd_q  <= 4'd0;
            gray_q  <= 4'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            opnd_q  <= opnd_d;
            gray_q  <= gray_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        opnd_d  = opnd_q;
        gray_d  = gray_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        // On a tie the requester that was not served last wins.
        pick    = (req0 && req1) ? ~ptr_q : req1;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = pick;
                    opnd_d  = pick ? bcd1 : bcd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (opnd_q <= 4'd9) begin
                    gray_d = opnd_q ^ (opnd_q >> 1);
                    err_d  = 1'b0;
                end else begin
                    gray_d = 4'd0;
                    err_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                ptr_d = sel_q;
                if (!err_q)
                    cnt_d = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign gnt0       = busy & ~sel_q;
    assign gnt1       = busy & sel_q;
    assign done0      = (state_q == RESP) & ~sel_q;
    assign done1      = (state_q == RESP) & sel_q;
    assign gray       = gray_q;
    assign err        = err_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_bcd_gray_arbiter.sv
// Directed bench for bcd_gray_arbiter; a second instance with CNT_W=2 checks counter wrap.
module tb_bcd_gray_arbiter;

    logic       clk = 1'b0;
    logic       rst, req0, req1;
    logic [3:0] bcd0, bcd1;
    logic       gnt0, gnt1, done0, done1, err, busy;
    logic [3:0] gray;
    logic [7:0] conv_count;
    logic       w_gnt0, w_gnt1, w_done0, w_done1, w_err, w_busy;
    logic [3:0] w_gray;
    logic [1:0] w_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_done_cyc;
    int done_order[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_gray_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .bcd0(bcd0), .req1(req1), .bcd1(bcd1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .gray(gray), .err(err), .busy(busy), .conv_count(conv_count)
    );

    bcd_gray_arbiter #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .req0(req0), .bcd0(bcd0), .req1(req1), .bcd1(bcd1),
        .gnt0(w_gnt0), .gnt1(w_gnt1), .done0(w_done0), .done1(w_done1),
        .gray(w_gray), .err(w_err), .busy(w_busy), .conv_count(w_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One full transaction from IDLE; req is dropped after grant.
    task automatic xact(input int who, input logic [3:0] d,
                        input logic [3:0] exp_gray, input logic exp_err);
        if (who == 0) begin req0 = 1'b1; bcd0 = d; end
        else          begin req1 = 1'b1; bcd1 = d; end
        tick();
        chk("grant", {gnt1, gnt0, busy}, (who == 0) ? 3'b011 : 3'b101);
        chk("no_done_in_load", {done1, done0}, 2'b00);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("done", {done1, done0, gnt1, gnt0}, (who == 0) ? 4'b0101 : 4'b1010);
        chk("gray", gray, exp_gray);
        chk("err", err, exp_err);
        last_done_cyc = cyc;
        tick();
        chk("idle_after", {done1, done0, gnt1, gnt0, busy}, 5'b0);
    endtask

    initial begin
        int prev;
        bcd0 = 4'd0; bcd1 = 4'd0;
        do_reset();
        chk("reset_outs", {gnt0, gnt1, done0, done1, err, busy}, 6'b0);
        chk("reset_gray", gray, 4'b0000);
        chk("reset_cnt", conv_count, 8'd0);
        chk("reset_cnt_w", w_count, 2'd0);

        // Single requester 0 transaction
        xact(0, 4'd7, 4'b0100, 1'b0);
        chk("cnt_after_7", conv_count, 8'd1);

        // Back-to-back requester 1 digits with 3-cycle done spacing
        do_reset();
        xact(1, 4'd0, 4'b0000, 1'b0); prev = last_done_cyc;
        xact(1, 4'd3, 4'b0010, 1'b0); chk("spacing_3", last_done_cyc - prev, 3); prev = last_done_cyc;
        xact(1, 4'd5, 4'b0111, 1'b0); chk("spacing_5", last_done_cyc - prev, 3); prev = last_done_cyc;
        xact(1, 4'd9, 4'b1101, 1'b0); chk("spacing_9", last_done_cyc - prev, 3);
        chk("cnt_after_4", conv_count, 8'd4);

        // Non-BCD operand flags error and leaves the count alone
        xact(0, 4'd12, 4'b0000, 1'b1);
        chk("cnt_after_err", conv_count, 8'd4);
        xact(0, 4'd9, 4'b1101, 1'b0);
        chk("cnt_after_9", conv_count, 8'd5);

        // Both requesters held: service alternates 0,1,0,1
        do_reset();
        req0 = 1'b1; bcd0 = 4'd2; req1 = 1'b1; bcd1 = 4'd8;
        done_order.delete();
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("gnt_excl", gnt0 & gnt1, 1'b0);
            chk("done_excl", done0 & done1, 1'b0);
            if (done0) begin done_order.push_back(0); chk("gray_2", gray, 4'b0011); end
            if (done1) begin done_order.push_back(1); chk("gray_8", gray, 4'b1100); end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_count", done_order.size(), 4);
        if (done_order.size() == 4)
            chk("rr_order", {done_order[0][0], done_order[1][0], done_order[2][0], done_order[3][0]}, 4'b0101);

        // Reset during LOAD abandons the transaction
        do_reset();
        req0 = 1'b1; bcd0 = 4'd5;
        tick();
        chk("mid_load", {gnt0, busy}, 2'b11);
        rst = 1'b1; req0 = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_outs", {gnt0, gnt1, done0, done1, err, busy}, 6'b0);
        chk("abort_gray", gray, 4'b0000);
        chk("abort_cnt", conv_count, 8'd0);
        tick();
        chk("abort_no_done", {done0, done1}, 2'b00);
        xact(1, 4'd4, 4'b0110, 1'b0);
        chk("cnt_after_abort", conv_count, 8'd1);

        // CNT_W=2 wrap: 1,2,3,0,1
        do_reset();
        xact(0, 4'd1, 4'b0001, 1'b0); chk("wrap_1", w_count, 2'd1);
        xact(1, 4'd6, 4'b0101, 1'b0); chk("wrap_2", w_count, 2'd2);
        xact(0, 4'd8, 4'b1100, 1'b0); chk("wrap_3", w_count, 2'd3);
        xact(1, 4'd2, 4'b0011, 1'b0); chk("wrap_0", w_count, 2'd0);
        xact(0, 4'd3, 4'b0010, 1'b0); chk("wrap_1b", w_count, 2'd1);
        chk("wide_cnt_5", conv_count, 8'd5);

        // Operand captured at grant; later bcd changes are ignored
        req0 = 1'b1; bcd0 = 4'd3;
        tick();
        bcd0 = 4'd9; req0 = 1'b0;
        tick();
        chk("capture_done", done0, 1'b1);
        chk("capture_gray", gray, 4'b0010);
        chk("capture_err", err, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
